// File: rtl/modred_arbiter.sv
// Round-robin front end for a shared modular-reduction pipeline; results return RED_LAT+1 cycles after handshake, no response back-pressure.
// Modulus reloads drain the pipeline first. Define MODRED_ARB_PERF_EN to add the perf_issued/perf_stall counters.
module modred_arbiter #(
  parameter int DATA_SIZE_ARB = 32,
  parameter int NUM_REQ       = 4,
  parameter int RED_LAT       = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cfg_we,
  input  logic [DATA_SIZE_ARB-1:0]           cfg_q,
  output logic                               cfg_done,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*2*DATA_SIZE_ARB-1:0] req_P,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [2*DATA_SIZE_ARB-1:0]         red_P,
  output logic [DATA_SIZE_ARB-1:0]           red_q,
  input  logic [DATA_SIZE_ARB-1:0]           red_C,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_SIZE_ARB-1:0]           rsp_data,
  output logic                               busy
`ifdef MODRED_ARB_PERF_EN
  ,
  output logic [31:0]                        perf_issued,
  output logic [31:0]                        perf_stall
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_UNCFG = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_LOAD  = 2'd3;

  logic [1:0]               state;
  logic [DATA_SIZE_ARB-1:0] pend_q;
  logic [IDW-1:0]           rr_ptr;
  logic                     grant_hit;
  logic [IDW-1:0]           grant_id;
  logic [IDW-1:0]           next_ptr;
  int                       idx;

  // Stage 0 travels alongside red_P; stage RED_LAT lines up with a valid red_C.
  logic [RED_LAT:0]          fl_vld;
  logic [RED_LAT:0][IDW-1:0] fl_id;

  always_comb begin
    req_ready = '0;
    grant_hit = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (state == ST_RUN && !cfg_we) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_hit && req_valid[IDW'(idx)]) begin
          grant_hit = 1'b1;
          grant_id  = IDW'(idx);
        end
      end
      if (grant_hit) req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    if (grant_id == IDW'(NUM_REQ - 1)) next_ptr = '0;
    else                               next_ptr = grant_id + IDW'(1);
  end

  assign busy = (state != ST_RUN) || (|fl_vld);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_UNCFG;
      pend_q    <= '0;
      red_q     <= '0;
      cfg_done  <= 1'b0;
      rr_ptr    <= '0;
      red_P     <= '0;
      fl_vld    <= '0;
      fl_id     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      cfg_done <= 1'b0;
      fl_vld   <= {fl_vld[RED_LAT-1:0], grant_hit};
      fl_id    <= {fl_id[RED_LAT-1:0], grant_id};

      if (grant_hit) begin
        red_P  <= req_P[grant_id*2*DATA_SIZE_ARB +: 2*DATA_SIZE_ARB];
        rr_ptr <= next_ptr;
      end

      if (fl_vld[RED_LAT]) begin
        rsp_valid <= NUM_REQ'(1) << fl_id[RED_LAT];
        rsp_data  <= red_C;
      end else begin
        rsp_valid <= '0;
      end

      case (state)
        ST_UNCFG: begin
          if (cfg_we) begin
            pend_q <= cfg_q;
            state  <= ST_LOAD;
          end
        end
        ST_RUN: begin
          if (cfg_we) begin
            pend_q <= cfg_q;
            state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Old-modulus results must all leave before red_q changes under them.
          if (fl_vld == '0) state <= ST_LOAD;
        end
        default: begin
          red_q    <= pend_q;
          cfg_done <= 1'b1;
          state    <= ST_RUN;
        end
      endcase
    end
  end

`ifdef MODRED_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (grant_hit)                 perf_issued <= perf_issued + 32'd1;
      if (|req_valid && !grant_hit)  perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_modred_arbiter.sv
// Bench for modred_arbiter: directed phases with random products, checked against a queue-based reference model.
module tb_modred_arbiter;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int LAT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_we;
  logic [W-1:0]     cfg_q;
  logic             cfg_done;
  logic [N-1:0]     req_valid;
  logic [N*2*W-1:0] req_P;
  logic [N-1:0]     req_ready;
  logic [2*W-1:0]   red_P;
  logic [W-1:0]     red_q;
  logic [W-1:0]     red_C;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_data;
  logic             busy;
`ifdef MODRED_ARB_PERF_EN
  logic [31:0]      perf_issued;
  logic [31:0]      perf_stall;
`endif

  modred_arbiter #(.DATA_SIZE_ARB(W), .NUM_REQ(N), .RED_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_done(cfg_done),
    .req_valid(req_valid), .req_P(req_P), .req_ready(req_ready),
    .red_P(red_P), .red_q(red_q), .red_C(red_C),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
`ifdef MODRED_ARB_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in reduction unit: result valid LAT cycles after red_P is presented.
  logic [W-1:0] red_pipe [LAT];
  always @(posedge clk) begin
    red_pipe[0] <= (red_q == '0) ? '0 : W'(red_P % {32'b0, red_q});
    for (int k = 1; k < LAT; k++) red_pipe[k] <= red_pipe[k-1];
  end
  assign red_C = red_pipe[LAT-1];

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] data;
  } exp_t;

  exp_t         expq[$];
  int           cyc;
  bit           m_uncfg, m_run;
  int           m_cfg_edge;
  logic [W-1:0] m_q, m_pend;
  int           m_ptr;
  int           m_issued, m_stall;
  int           n_assert = 0;
  int           n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    expq.delete();
    m_uncfg = 1'b1; m_run = 1'b0; m_cfg_edge = -1;
    m_q = '0; m_pend = '0; m_ptr = 0; m_issued = 0; m_stall = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cfg_we = 1'b0; req_valid = '0;
    @(posedge clk); cyc++; #1;
    chk("rst_ready", req_ready, '0);
    chk("rst_red_P", red_P, '0);
    chk("rst_red_q", red_q, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_cfg_done", cfg_done, 1'b0);
    chk("rst_busy", busy, 1'b1);
`ifdef MODRED_ARB_PERF_EN
    chk("rst_perf_issued", perf_issued, '0);
    chk("rst_perf_stall", perf_stall, '0);
`endif
    reset = 1'b0;
    model_clear();
  endtask

  task automatic rand_prods();
    for (int i = 0; i < N; i++) req_P[i*2*W +: 2*W] = {$urandom, $urandom};
  endtask

  // One clock: check grant before the edge, then responses/config/busy after it.
  task automatic tick();
    logic [N-1:0]   er;
    logic [N-1:0]   oh;
    logic [2*W-1:0] p;
    exp_t           e;
    int             g, last, i;
    #1;
    er = '0; g = -1;
    if (m_run && !cfg_we) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    if (|req_valid && g < 0) m_stall++;
    if (g >= 0) begin
      p      = req_P[g*2*W +: 2*W];
      e.due  = cyc + 1 + LAT + 1;
      e.id   = g;
      e.data = W'(p % {32'b0, m_q});
      expq.push_back(e);
      m_ptr  = (g + 1) % N;
      m_issued++;
    end
    if (cfg_we && m_cfg_edge < 0) begin
      if (m_uncfg) begin
        m_uncfg = 1'b0; m_pend = cfg_q; m_cfg_edge = cyc + 2;
      end else if (m_run) begin
        m_run = 1'b0; m_pend = cfg_q;
        last = (expq.size() > 0) ? expq[$].due : 0;
        m_cfg_edge = ((last > cyc + 1) ? last : cyc + 1) + 2;
      end
    end
    @(posedge clk); cyc++; #1;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      oh = '0; oh[expq[0].id] = 1'b1;
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_data", rsp_data, expq[0].data);
      void'(expq.pop_front());
    end else begin
      chk("rsp_idle", rsp_valid, '0);
    end
    chk("cfg_done", cfg_done, (cyc == m_cfg_edge));
    if (cyc == m_cfg_edge) begin
      m_q = m_pend; m_run = 1'b1; m_cfg_edge = -1;
      chk("red_q_loaded", red_q, m_q);
    end
    chk("busy", busy, (!m_run || expq.size() > 0));
  endtask

  initial begin
    int guard;
    reset = 1'b1; cfg_we = 1'b0; cfg_q = '0; req_valid = '0; req_P = '0; cyc = 0;
    model_clear();
    do_reset();

    // First modulus load from UNCFG.
    cfg_we = 1'b1; cfg_q = 32'hFFFF_FFFB;
    tick();
    cfg_we = 1'b0;
    tick();
    tick();
    chk("cfg_red_q", red_q, 32'hFFFF_FFFB);
    chk("cfg_busy_low", busy, 1'b0);

    // Single request from requester 2: (2^32+5) mod (2^32-5) = 10.
    req_valid = 4'b0100;
    req_P[2*2*W +: 2*W] = 64'h1_0000_0005;
    tick();
    req_valid = '0;
    repeat (5) tick();
    chk("single_rsp_valid", rsp_valid, 4'b0100);
    chk("single_rsp_data", rsp_data, 32'd10);
    repeat (2) tick();

    // All four requesters continuously.
    req_valid = 4'hF;
    for (int c = 0; c < 16; c++) begin rand_prods(); tick(); end
    req_valid = '0;
    repeat (8) tick();

    // Requesters 1 and 3 only.
    req_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin rand_prods(); tick(); end
    req_valid = '0;
    repeat (8) tick();

    // Random request masks.
    for (int c = 0; c < 40; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      rand_prods();
      tick();
    end
    req_valid = '0;
    repeat (8) tick();
`ifdef MODRED_ARB_PERF_EN
    chk("perf_issued", perf_issued, 32'(m_issued));
    chk("perf_stall", perf_stall, 32'(m_stall));
`endif

    // Modulus reload with three operations in flight.
    req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin rand_prods(); tick(); end
    cfg_we = 1'b1; cfg_q = $urandom | 32'h8000_0001;
    tick();
    cfg_we = 1'b0;
    guard = 0;
    while (!m_run && guard < 40) begin tick(); guard++; end
    chk("reload_in_time", (guard < 40), 1'b1);
    for (int c = 0; c < 8; c++) begin rand_prods(); tick(); end
    req_valid = '0;
    repeat (8) tick();

    // Reset with operations in flight: nothing may be reported afterwards.
    req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin rand_prods(); tick(); end
    req_valid = '0;
    repeat (2) tick();
    do_reset();
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
